// File: rtl/cv32e40p_x_if_multi_dispatch_if.sv
// Bundle of the core-side X-interface and the broadcast coprocessor-side signals
// seen by the multi-coprocessor dispatcher.
interface cv32e40p_x_if_multi_dispatch_if #(
  parameter int NUM_COPROC = 2
);
  logic                       x_valid_i;
  logic                       x_ready_o;
  logic [31:0]                x_instr_data_i;
  logic [2:0][31:0]           x_rs_i;
  logic [2:0]                 x_rs_valid_i;
  logic                       x_rd_clean_i;
  logic                       x_accept_o;
  logic                       x_is_mem_op_o;
  logic                       x_writeback_o;
  logic                       x_rvalid_o;
  logic                       x_rready_i;
  logic [4:0]                 x_rd_o;
  logic [31:0]                x_data_o;
  logic                       x_dualwb_o;
  logic                       x_error_o;
  logic [NUM_COPROC-1:0]      cp_valid_o;
  logic [NUM_COPROC-1:0]      cp_ready_i;
  logic [31:0]                cp_instr_data_o;
  logic [2:0][31:0]           cp_rs_o;
  logic [2:0]                 cp_rs_valid_o;
  logic                       cp_rd_clean_o;
  logic [NUM_COPROC-1:0]      cp_accept_i;
  logic [NUM_COPROC-1:0]      cp_is_mem_op_i;
  logic [NUM_COPROC-1:0]      cp_writeback_i;
  logic [NUM_COPROC-1:0]      cp_rvalid_i;
  logic [NUM_COPROC-1:0]      cp_rready_o;
  logic [NUM_COPROC*5-1:0]    cp_rd_i;
  logic [NUM_COPROC*32-1:0]   cp_data_i;
  logic [NUM_COPROC-1:0]      cp_dualwb_i;
  logic [NUM_COPROC-1:0]      cp_error_i;

  modport slave (
    input  x_valid_i, x_instr_data_i, x_rs_i, x_rs_valid_i, x_rd_clean_i, x_rready_i,
           cp_ready_i, cp_accept_i, cp_is_mem_op_i, cp_writeback_i, cp_rvalid_i,
           cp_rd_i, cp_data_i, cp_dualwb_i, cp_error_i,
    output x_ready_o, x_accept_o, x_is_mem_op_o, x_writeback_o, x_rvalid_o, x_rd_o,
           x_data_o, x_dualwb_o, x_error_o, cp_valid_o, cp_instr_data_o, cp_rs_o,
           cp_rs_valid_o, cp_rd_clean_o, cp_rready_o
  );

  modport master (
    output x_valid_i, x_instr_data_i, x_rs_i, x_rs_valid_i, x_rd_clean_i, x_rready_i,
           cp_ready_i, cp_accept_i, cp_is_mem_op_i, cp_writeback_i, cp_rvalid_i,
           cp_rd_i, cp_data_i, cp_dualwb_i, cp_error_i,
    input  x_ready_o, x_accept_o, x_is_mem_op_o, x_writeback_o, x_rvalid_o, x_rd_o,
           x_data_o, x_dualwb_o, x_error_o, cp_valid_o, cp_instr_data_o, cp_rs_o,
           cp_rs_valid_o, cp_rd_clean_o, cp_rready_o
  );
endinterface

// File: rtl/cv32e40p_x_if_multi_dispatch.sv
// Broadcasts X-interface offloads to NUM_COPROC coprocessors, picks the lowest-index
// acceptor and returns writeback results to the core in offload order.
module cv32e40p_x_if_multi_dispatch #(
  parameter int NUM_COPROC = 2,
  parameter int DEPTH      = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  cv32e40p_x_if_multi_dispatch_if.slave xif,
  output logic                     multi_accept_o,
  output logic [$clog2(DEPTH):0]   inflight_o
);
  localparam int PW   = $clog2(DEPTH);
  localparam int IDXW = (NUM_COPROC > 1) ? $clog2(NUM_COPROC) : 1;
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  logic [DEPTH-1:0][IDXW-1:0] order_q;
  logic [PW-1:0]              wr_ptr, rd_ptr;
  logic                       full, empty, fired, push, pop, multi_hit;
  logic [IDXW-1:0]            win, head;
  logic                       win_found, win_mem, win_wb;
  logic                       h_rvalid, h_dualwb, h_error;
  logic [4:0]                 h_rd;
  logic [31:0]                h_data;

  assign full  = (inflight_o == FULL_CNT);
  assign empty = (inflight_o == '0);

  // request broadcast
  assign xif.x_ready_o       = (&xif.cp_ready_i) & ~full;
  assign xif.cp_valid_o      = {NUM_COPROC{xif.x_valid_i & ~full}};
  assign xif.cp_instr_data_o = xif.x_instr_data_i;
  assign xif.cp_rs_o         = xif.x_rs_i;
  assign xif.cp_rs_valid_o   = xif.x_rs_valid_i;
  assign xif.cp_rd_clean_o   = xif.x_rd_clean_i;
  assign fired               = xif.x_valid_i & xif.x_ready_o;

  always_comb begin
    win       = '0;
    win_found = 1'b0;
    win_mem   = 1'b0;
    win_wb    = 1'b0;
    for (int i = 0; i < NUM_COPROC; i++) begin
      if (xif.cp_accept_i[i] && !win_found) begin
        win       = IDXW'(i);
        win_found = 1'b1;
        win_mem   = xif.cp_is_mem_op_i[i];
        win_wb    = xif.cp_writeback_i[i];
      end
    end
  end

  // more than one bit set <=> clearing the lowest set bit leaves something
  assign multi_hit         = |(xif.cp_accept_i & (xif.cp_accept_i - NUM_COPROC'(1)));
  assign xif.x_accept_o    = fired & win_found;
  assign xif.x_is_mem_op_o = fired & win_found & win_mem;
  assign xif.x_writeback_o = fired & win_found & win_wb;
  assign push              = xif.x_accept_o & xif.x_writeback_o;

  // response return from the oldest outstanding writeback
  assign head = order_q[rd_ptr];

  always_comb begin
    h_rvalid        = 1'b0;
    h_rd            = '0;
    h_data          = '0;
    h_dualwb        = 1'b0;
    h_error         = 1'b0;
    xif.cp_rready_o = '0;
    for (int i = 0; i < NUM_COPROC; i++) begin
      if (IDXW'(i) == head) begin
        h_rvalid           = xif.cp_rvalid_i[i];
        h_rd               = xif.cp_rd_i[5*i +: 5];
        h_data             = xif.cp_data_i[32*i +: 32];
        h_dualwb           = xif.cp_dualwb_i[i];
        h_error            = xif.cp_error_i[i];
        xif.cp_rready_o[i] = ~empty & xif.x_rready_i;
      end
    end
  end

  assign xif.x_rvalid_o = ~empty & h_rvalid;
  assign xif.x_rd_o     = empty ? '0 : h_rd;
  assign xif.x_data_o   = empty ? '0 : h_data;
  assign xif.x_dualwb_o = ~empty & h_dualwb;
  assign xif.x_error_o  = ~empty & h_error;
  assign pop            = xif.x_rvalid_o & xif.x_rready_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      order_q        <= '0;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      inflight_o     <= '0;
      multi_accept_o <= 1'b0;
    end else begin
      if (push) begin
        order_q[wr_ptr] <= win;
        wr_ptr          <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   inflight_o <= inflight_o + (PW+1)'(1);
        2'b01:   inflight_o <= inflight_o - (PW+1)'(1);
        default: inflight_o <= inflight_o;
      endcase
      if (fired && multi_hit) multi_accept_o <= 1'b1;
    end
  end
endmodule
